breath_pwm_multi: RTL

//   Multi-channel breathing-LED driver: per-channel triangle-ramped PWM duty, phase-staggered.

---
 rtl/breath_pwm_multi.sv | 131 +++++++++++++
 1 files changed

// File: rtl/breath_pwm_multi.sv
// Multi-channel breathing-LED PWM driver with phase-staggered triangle ramps.
// Optional square-law brightness curve in breathe mode when BREATH_GAMMA_EN is defined.
module breath_pwm_multi #(
  parameter int unsigned CH           = 4,
  parameter int unsigned PWM_W        = 8,
  parameter int unsigned PRESCALE     = 1000,
  parameter int unsigned STEP_PERIODS = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [PWM_W-1:0] level,
  output logic [CH-1:0]    led,
  output logic             cycle_done
);

  localparam int unsigned PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned ST_W    = (STEP_PERIODS > 1) ? $clog2(STEP_PERIODS) : 1;
  localparam int unsigned SPACING = (1 << PWM_W) / CH;
  localparam logic [PWM_W-1:0] MAX = '1;

  localparam logic [1:0] MODE_BREATHE = 2'd0;
  localparam logic [1:0] MODE_STATIC  = 2'd1;
  localparam logic [1:0] MODE_ON      = 2'd3;

  logic [PS_W-1:0]            prescaler;
  logic [PWM_W-1:0]           pwm_cnt;
  logic [ST_W-1:0]            step_cnt;
  logic [CH-1:0][PWM_W-1:0]   duty;
  logic [CH-1:0]              dir_down;
  logic [1:0]                 mode_q;
  logic [PWM_W-1:0]           level_q;

  logic                       tick_c;
  logic                       boundary_c;
  logic                       step_c;
  logic                       done_c;
  logic [CH-1:0][PWM_W-1:0]   duty_d;
  logic [CH-1:0]              dir_d;
  logic [CH-1:0][PWM_W-1:0]   cmp_c;
  logic [CH-1:0]              led_d;
`ifdef BREATH_GAMMA_EN
  logic [CH-1:0][2*PWM_W-1:0] sq_c;
`endif

  // Tick/boundary/step decode and per-channel triangle ramp next-state.
  always_comb begin
    tick_c     = (prescaler == PS_W'(PRESCALE - 1));
    boundary_c = en && tick_c && (pwm_cnt == MAX);
    step_c     = boundary_c && (mode_q == MODE_BREATHE) &&
                 (step_cnt == ST_W'(STEP_PERIODS - 1));
    done_c     = step_c && dir_down[0] && (duty[0] == PWM_W'(1));
    duty_d     = duty;
    dir_d      = dir_down;
    if (step_c) begin
      for (int i = 0; i < CH; i++) begin
        if (!dir_down[i]) begin
          if (duty[i] == MAX) begin
            dir_d[i]  = 1'b1;
            duty_d[i] = MAX - PWM_W'(1);
          end else begin
            duty_d[i] = duty[i] + PWM_W'(1);
          end
        end else begin
          if (duty[i] == '0) begin
            dir_d[i]  = 1'b0;
            duty_d[i] = PWM_W'(1);
          end else begin
            duty_d[i] = duty[i] - PWM_W'(1);
          end
        end
      end
    end
  end

  // Compare value selection and next LED level.
  always_comb begin
    cmp_c = '0;
    led_d = '0;
`ifdef BREATH_GAMMA_EN
    sq_c  = '0;
`endif
    for (int i = 0; i < CH; i++) begin
`ifdef BREATH_GAMMA_EN
      sq_c[i] = (2*PWM_W)'(duty[i]) * (2*PWM_W)'(duty[i]);
      cmp_c[i] = (mode_q == MODE_BREATHE) ? sq_c[i][2*PWM_W-1:PWM_W] : level_q;
`else
      cmp_c[i] = (mode_q == MODE_BREATHE) ? duty[i] : level_q;
`endif
      led_d[i] = en && ((mode_q == MODE_ON) ||
                        ((mode_q == MODE_BREATHE || mode_q == MODE_STATIC) &&
                         (pwm_cnt < cmp_c[i])));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescaler  <= '0;
      pwm_cnt    <= '0;
      step_cnt   <= '0;
      dir_down   <= '0;
      mode_q     <= MODE_BREATHE;
      level_q    <= '0;
      led        <= '0;
      cycle_done <= 1'b0;
      for (int i = 0; i < CH; i++) begin
        duty[i] <= PWM_W'(i * SPACING);
      end
    end else begin
      led        <= led_d;
      cycle_done <= done_c;
      if (en) begin
        prescaler <= tick_c ? '0 : prescaler + PS_W'(1);
        if (tick_c) begin
          pwm_cnt <= pwm_cnt + PWM_W'(1);
        end
        if (boundary_c) begin
          mode_q  <= mode;
          level_q <= level;
          if (mode_q == MODE_BREATHE) begin
            step_cnt <= step_c ? '0 : step_cnt + ST_W'(1);
          end
        end
        duty     <= duty_d;
        dir_down <= dir_d;
      end
    end
  end

endmodule
